bso_ctrl: RTL and testbench
===========================

# bso_ctrl

Ball/strike/out scoreboard controller for the baseball electronic display. It consumes the single-cycle event pulses produced by the per-button pulse generators. It arbitrates simultaneous events and sequences the count, out, half-inning and inning registers. After a walk, strikeout or third out it holds the full count on the display for a fixed time before clearing. Its outputs drive the display decoders directly.

## Interface

Parameters:
- INNINGS, 9: regulation innings. Range 1–15.
- HOLD_CYC, 4: cycles the final count is held before clearing. Must be ≥1.

Ports:
- iCLK, in, 1: clock. Single clock domain.
- iRST, in, 1: reset. Synchronous, active-high.
- iBALL, in, 1: ball event. 1-cycle pulse.
- iSTRIKE, in, 1: called or swinging strike. Pulse.
- iFOUL, in, 1: foul ball. Pulse.
- iHIT, in, 1: batter reaches base. Pulse.
- iOUT, in, 1: batter retired in play. Pulse.
- oBALL, out, 2: ball count, 0–3.
- oSTRIKE, out, 2: strike count, 0–2.
- oOUT, out, 2: out count, 0–3.
- oINNING, out, 4: current inning, 1..INNINGS.
- oHALF, out, 1: 0 = top, 1 = bottom.
- oWALK, out, 1: 1-cycle pulse on the 4th ball.
- oSO, out, 1: 1-cycle pulse on strike 3.
- oSIDE, out, 1: 1-cycle pulse on the 3rd out.
- oBUSY, out, 1: high while in HOLD_BAT or HOLD_SIDE.
- oOVER, out, 1: game finished.

## Operation

- Reset values:
  - oINNING = 1.
  - All other outputs = 0.
  - State = IDLE.
- States:
  - IDLE, HOLD_BAT, HOLD_SIDE, OVER.
  - All outputs are registered.
- Arbitration in IDLE: when several pulses are high in the same cycle, only the highest-priority one is taken. Priority: iOUT > iHIT > iSTRIKE > iFOUL > iBALL. Lower-priority pulses are dropped, not queued.
- Event rules in IDLE:
  - iBALL, ball < 3: ball +1.
  - iBALL, ball = 3: oWALK pulse; ball stays at 3; go to HOLD_BAT.
  - iSTRIKE, strike < 2: strike +1.
  - iSTRIKE, strike = 2: oSO pulse; strike stays at 2; out +1. If out becomes 3: oSIDE pulse and go to HOLD_SIDE. Otherwise go to HOLD_BAT.
  - iFOUL: strike +1 only if strike < 2. Otherwise no change.
  - iHIT: ball and strike cleared to 0. Stay in IDLE.
  - iOUT: ball and strike cleared; out +1. If out becomes 3: oSIDE pulse and go to HOLD_SIDE.
- HOLD_BAT: all inputs are ignored. On expiry: ball and strike cleared, return to IDLE.
- HOLD_SIDE: all inputs are ignored. On expiry:
  - ball, strike and out cleared.
  - If oHALF = 0: oHALF ← 1.
  - If oHALF = 1 and inning < INNINGS: oHALF ← 0, inning +1.
  - If oHALF = 1 and inning = INNINGS: go to OVER.
- Otherwise HOLD_SIDE returns to IDLE.
- OVER:
  - oOVER = 1.
  - Counts are frozen at their displayed values, i.e. ball and strike at 0 and out cleared to 0.
  - All inputs are ignored until iRST.
- Width rule: all counts saturate at their stated maxima and never wrap.

## Timing

- Event latency: a pulse sampled at edge N is visible on the count outputs after edge N.
- oWALK, oSO and oSIDE are high for exactly the one cycle following edge N.
- oBUSY rises together with the event pulse.
- Hold duration: if a hold is entered at edge N, the state leaves hold at edge N+HOLD_CYC. The cleared counts and oBUSY = 0 appear in the same cycle.
- Simultaneous pulses: only one event is taken per cycle (see priority above).
- A pulse arriving in the cycle that leaves hold (edge N+HOLD_CYC) is ignored. The first pulse accepted is at edge N+HOLD_CYC+1.
- iRST wins over every event and every state, including mid-hold and OVER. All outputs take their reset values on the next cycle.
- Inputs held high for longer than 1 cycle count once per cycle; pulse shaping is upstream.

## Structure

- Package bso_pkg holds:
  - The state enum: IDLE, HOLD_BAT, HOLD_SIDE, OVER.
  - Count limits: MAX_BALL = 3, MAX_STRIKE = 2, MAX_OUT = 3.
  - The event-priority encoding.
- One sub-module, hold_timer:
  - Loadable down-counter sized to $clog2(HOLD_CYC+1).
  - Ports: iCLK, iRST, iSTART, oDONE.
  - oDONE is high in the cycle the count reaches 0.
- Arbitration, count registers and the FSM stay in bso_ctrl.

## Test plan

- Walk, HOLD_CYC=4: four iBALL pulses →
  - oBALL shows 1, 2, 3, 3.
  - oWALK is high 1 cycle after the 4th pulse.
  - oBUSY is high for 4 cycles, then oBALL = 0 and oSTRIKE = 0.
- Foul saturation and strikeout: iFOUL ×3 → oSTRIKE = 2. Then iSTRIKE →
  - oSO pulse; oOUT = 1.
  - After the hold, strike = 0.
- Simultaneous events: iBALL, iFOUL and iOUT in the same cycle, from count 2-1 with 0 outs →
  - oOUT = 1, oBALL = 0, oSTRIKE = 0.
  - No oWALK pulse.
- Side retired: three iOUT pulses in the top of inning 1 →
  - oSIDE pulse; inputs during the hold are ignored.
  - Then oHALF = 1, oINNING = 1, oOUT = 0.
  - Three more iOUT pulses → oHALF = 0, oINNING = 2.
- Game over, INNINGS=1: retire both halves → oOVER = 1. Further pulses change nothing; iRST restores oINNING = 1.
- Reset mid-hold: assert iRST during HOLD_BAT → all outputs at reset values the next cycle. The next iBALL gives oBALL = 1.

Source files
------------

// File: rtl/bso_pkg.sv
// rtl/bso_pkg.sv - shared state codes, count limits and event arbitration for bso_ctrl
package bso_pkg;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_HOLD_BAT  = 2'd1;
  localparam logic [1:0] S_HOLD_SIDE = 2'd2;
  localparam logic [1:0] S_OVER      = 2'd3;

  localparam logic [1:0] MAX_BALL   = 2'd3;
  localparam logic [1:0] MAX_STRIKE = 2'd2;
  localparam logic [1:0] MAX_OUT    = 2'd3;

  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_BALL   = 3'd1,
    EV_FOUL   = 3'd2,
    EV_STRIKE = 3'd3,
    EV_HIT    = 3'd4,
    EV_OUT    = 3'd5
  } ev_t;

  // Lower-priority pulses in the same cycle are dropped outright.
  function automatic ev_t arbitrate(input logic b, input logic s, input logic f,
                                    input logic h, input logic o);
    if (o)      return EV_OUT;
    else if (h) return EV_HIT;
    else if (s) return EV_STRIKE;
    else if (f) return EV_FOUL;
    else if (b) return EV_BALL;
    else        return EV_NONE;
  endfunction

endpackage

// File: rtl/bso_ctrl_hold_timer.sv
// rtl/bso_ctrl_hold_timer.sv - loadable down-counter timing the final-count display hold
module hold_timer #(
  parameter int HOLD_CYC = 4
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iSTART,
  output logic oDONE
);

  localparam int W = $clog2(HOLD_CYC + 1);
  localparam logic [W-1:0] LOAD = W'(HOLD_CYC - 1);

  logic [W-1:0] r_cnt;
  logic         r_run;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (iSTART) begin
      r_cnt <= LOAD;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - W'(1);
    end
  end

  assign oDONE = r_run && (r_cnt == '0);

endmodule

// File: rtl/bso_ctrl.sv
// rtl/bso_ctrl.sv - ball/strike/out scoreboard controller with arbitration and display hold
module bso_ctrl
  import bso_pkg::*;
#(
  parameter int INNINGS  = 9,
  parameter int HOLD_CYC = 4
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iBALL,
  input  logic       iSTRIKE,
  input  logic       iFOUL,
  input  logic       iHIT,
  input  logic       iOUT,
  output logic [1:0] oBALL,
  output logic [1:0] oSTRIKE,
  output logic [1:0] oOUT,
  output logic [3:0] oINNING,
  output logic       oHALF,
  output logic       oWALK,
  output logic       oSO,
  output logic       oSIDE,
  output logic       oBUSY,
  output logic       oOVER
);

  localparam logic [3:0] LAST_INN = 4'(INNINGS);

  logic [1:0] r_state;
  logic [1:0] r_ball, r_strike, r_out;
  logic [3:0] r_inning;
  logic       r_half, r_walk, r_so, r_side;

  ev_t  w_ev;
  logic w_idle, w_walk, w_so, w_side, w_start, w_done;

  assign w_ev    = arbitrate(iBALL, iSTRIKE, iFOUL, iHIT, iOUT);
  assign w_idle  = (r_state == S_IDLE);
  assign w_walk  = w_idle && (w_ev == EV_BALL) && (r_ball == MAX_BALL);
  assign w_so    = w_idle && (w_ev == EV_STRIKE) && (r_strike == MAX_STRIKE);
  // Third out may come from a batted-ball out or from the strikeout itself.
  assign w_side  = w_idle && ((w_ev == EV_OUT) || w_so) && (r_out == MAX_OUT - 2'd1);
  assign w_start = w_walk || w_so || w_side;

  hold_timer #(.HOLD_CYC(HOLD_CYC)) u_hold_timer (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iSTART (w_start),
    .oDONE  (w_done)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state  <= S_IDLE;
      r_ball   <= 2'd0;
      r_strike <= 2'd0;
      r_out    <= 2'd0;
      r_inning <= 4'd1;
      r_half   <= 1'b0;
      r_walk   <= 1'b0;
      r_so     <= 1'b0;
      r_side   <= 1'b0;
    end else begin
      r_walk <= w_walk;
      r_so   <= w_so;
      r_side <= w_side;
      case (r_state)
        S_IDLE: begin
          case (w_ev)
            EV_OUT: begin
              r_ball   <= 2'd0;
              r_strike <= 2'd0;
              r_out    <= r_out + 2'd1;
              if (w_side) r_state <= S_HOLD_SIDE;
            end
            EV_HIT: begin
              r_ball   <= 2'd0;
              r_strike <= 2'd0;
            end
            EV_STRIKE: begin
              if (w_so) begin
                r_out   <= r_out + 2'd1;
                r_state <= w_side ? S_HOLD_SIDE : S_HOLD_BAT;
              end else begin
                r_strike <= r_strike + 2'd1;
              end
            end
            EV_FOUL: begin
              if (r_strike < MAX_STRIKE) r_strike <= r_strike + 2'd1;
            end
            EV_BALL: begin
              if (w_walk) r_state <= S_HOLD_BAT;
              else        r_ball  <= r_ball + 2'd1;
            end
            default: ;
          endcase
        end
        S_HOLD_BAT: begin
          if (w_done) begin
            r_ball   <= 2'd0;
            r_strike <= 2'd0;
            r_state  <= S_IDLE;
          end
        end
        S_HOLD_SIDE: begin
          if (w_done) begin
            r_ball   <= 2'd0;
            r_strike <= 2'd0;
            r_out    <= 2'd0;
            if (!r_half) begin
              r_half  <= 1'b1;
              r_state <= S_IDLE;
            end else if (r_inning < LAST_INN) begin
              r_half   <= 1'b0;
              r_inning <= r_inning + 4'd1;
              r_state  <= S_IDLE;
            end else begin
              r_state <= S_OVER;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign oBALL   = r_ball;
  assign oSTRIKE = r_strike;
  assign oOUT    = r_out;
  assign oINNING = r_inning;
  assign oHALF   = r_half;
  assign oWALK   = r_walk;
  assign oSO     = r_so;
  assign oSIDE   = r_side;
  assign oBUSY   = (r_state == S_HOLD_BAT) || (r_state == S_HOLD_SIDE);
  assign oOVER   = (r_state == S_OVER);

endmodule

// File: tb/tb_bso_ctrl.sv
// tb/tb_bso_ctrl.sv - self-checking bench for bso_ctrl against a cycle-level scoreboard model
module tb_bso_ctrl;

  localparam int INN  = 2;
  localparam int HOLD = 4;

  logic       iCLK, iRST, iBALL, iSTRIKE, iFOUL, iHIT, iOUT;
  logic [1:0] oBALL, oSTRIKE, oOUT;
  logic [3:0] oINNING;
  logic       oHALF, oWALK, oSO, oSIDE, oBUSY, oOVER;

  int checks = 0;
  int failures = 0;

  bso_ctrl #(.INNINGS(INN), .HOLD_CYC(HOLD)) dut (
    .iCLK(iCLK), .iRST(iRST), .iBALL(iBALL), .iSTRIKE(iSTRIKE), .iFOUL(iFOUL),
    .iHIT(iHIT), .iOUT(iOUT), .oBALL(oBALL), .oSTRIKE(oSTRIKE), .oOUT(oOUT),
    .oINNING(oINNING), .oHALF(oHALF), .oWALK(oWALK), .oSO(oSO), .oSIDE(oSIDE),
    .oBUSY(oBUSY), .oOVER(oOVER)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  // Scoreboard model: plain integers plus a countdown of remaining hold cycles.
  int m_ball, m_strike, m_out, m_inn, m_hold;
  bit m_half, m_side_hold, m_over, m_walk, m_so, m_sidep;

  wire [16:0] w_obs = {oBALL, oSTRIKE, oOUT, oINNING, oHALF, oWALK, oSO, oSIDE, oBUSY, oOVER};

  function automatic logic [16:0] exp_vec();
    return {2'(m_ball), 2'(m_strike), 2'(m_out), 4'(m_inn), m_half,
            m_walk, m_so, m_sidep, (m_hold > 0), m_over};
  endfunction

  task automatic start_hold(input bit side);
    m_hold = HOLD;
    m_side_hold = side;
  endtask

  task automatic model_step(input bit b, input bit s, input bit f, input bit h,
                            input bit o, input bit r);
    m_walk = 0; m_so = 0; m_sidep = 0;
    if (r) begin
      m_ball = 0; m_strike = 0; m_out = 0; m_inn = 1; m_half = 0;
      m_hold = 0; m_over = 0; m_side_hold = 0;
    end else if (m_over) begin
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin
        m_ball = 0; m_strike = 0;
        if (m_side_hold) begin
          m_out = 0;
          if (!m_half) m_half = 1;
          else if (m_inn < INN) begin m_half = 0; m_inn++; end
          else m_over = 1;
        end
      end
    end else if (o) begin
      m_ball = 0; m_strike = 0; m_out++;
      if (m_out == 3) begin m_sidep = 1; start_hold(1); end
    end else if (h) begin
      m_ball = 0; m_strike = 0;
    end else if (s) begin
      if (m_strike < 2) m_strike++;
      else begin
        m_so = 1; m_out++;
        if (m_out == 3) begin m_sidep = 1; start_hold(1); end
        else start_hold(0);
      end
    end else if (f) begin
      if (m_strike < 2) m_strike++;
    end else if (b) begin
      if (m_ball < 3) m_ball++;
      else begin m_walk = 1; start_hold(0); end
    end
  endtask

  task automatic drive(input bit b, input bit s, input bit f, input bit h,
                       input bit o, input bit r);
    iBALL = b; iSTRIKE = s; iFOUL = f; iHIT = h; iOUT = o; iRST = r;
    @(posedge iCLK);
    model_step(b, s, f, h, o, r);
    @(negedge iCLK);
    iBALL = 0; iSTRIKE = 0; iFOUL = 0; iHIT = 0; iOUT = 0; iRST = 0;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 1, 1);
    checks++;
    if (w_obs !== exp_vec()) begin
      failures++; $display("FAIL reset got=%h exp=%h", w_obs, exp_vec());
    end
    checks++;
    if (oINNING !== 4'd1 || oOVER !== 1'b0 || oBUSY !== 1'b0) begin
      failures++; $display("FAIL reset_inning got=%0d/%b/%b exp=1/0/0", oINNING, oOVER, oBUSY);
    end
  endtask

  task automatic test_walk();
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      checks++;
      if (w_obs !== exp_vec()) begin
        failures++; $display("FAIL walk_ball%0d got=%h exp=%h", i, w_obs, exp_vec());
      end
    end
    checks++;
    if (oBALL !== 2'd3 || oWALK !== 1'b1 || oBUSY !== 1'b1) begin
      failures++; $display("FAIL walk_pulse got=%0d/%b/%b exp=3/1/1", oBALL, oWALK, oBUSY);
    end
    for (int i = 0; i < HOLD; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (w_obs !== exp_vec()) begin
        failures++; $display("FAIL walk_hold%0d got=%h exp=%h", i, w_obs, exp_vec());
      end
    end
    checks++;
    if (oBALL !== 2'd0 || oSTRIKE !== 2'd0 || oBUSY !== 1'b0) begin
      failures++; $display("FAIL walk_clear got=%0d/%0d/%b exp=0/0/0", oBALL, oSTRIKE, oBUSY);
    end
  endtask

  task automatic test_strikeout();
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 0);
    checks++;
    if (oSTRIKE !== 2'd2 || w_obs !== exp_vec()) begin
      failures++; $display("FAIL foul_sat got=%h exp=%h", w_obs, exp_vec());
    end
    drive(0, 1, 0, 0, 0, 0);
    checks++;
    if (oSO !== 1'b1 || oOUT !== 2'd1 || w_obs !== exp_vec()) begin
      failures++; $display("FAIL strikeout got=%h exp=%h", w_obs, exp_vec());
    end
    for (int i = 0; i < HOLD; i++) drive(0, 1, 1, 0, 0, 0);
    checks++;
    if (oSTRIKE !== 2'd0 || oOUT !== 2'd1 || w_obs !== exp_vec()) begin
      failures++; $display("FAIL so_clear got=%h exp=%h", w_obs, exp_vec());
    end
  endtask

  task automatic test_simultaneous();
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 1, 0);
    checks++;
    if (oOUT !== 2'd1 || oBALL !== 2'd0 || oSTRIKE !== 2'd0 || oWALK !== 1'b0
        || w_obs !== exp_vec()) begin
      failures++; $display("FAIL simultaneous got=%h exp=%h", w_obs, exp_vec());
    end
  endtask

  task automatic test_side();
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);
    checks++;
    if (oSIDE !== 1'b1 || oBUSY !== 1'b1 || w_obs !== exp_vec()) begin
      failures++; $display("FAIL side_pulse got=%h exp=%h", w_obs, exp_vec());
    end
    for (int i = 0; i < HOLD; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), 0);
      checks++;
      if (w_obs !== exp_vec()) begin
        failures++; $display("FAIL side_hold%0d got=%h exp=%h", i, w_obs, exp_vec());
      end
    end
    checks++;
    if (oHALF !== 1'b1 || oINNING !== 4'd1 || oOUT !== 2'd0) begin
      failures++; $display("FAIL side_bottom got=%b/%0d/%0d exp=1/1/0", oHALF, oINNING, oOUT);
    end
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < HOLD; i++) drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (oHALF !== 1'b0 || oINNING !== 4'd2 || w_obs !== exp_vec()) begin
      failures++; $display("FAIL side_next_inning got=%h exp=%h", w_obs, exp_vec());
    end
  endtask

  task automatic test_game_over();
    drive(0, 0, 0, 0, 0, 1);
    for (int hf = 0; hf < 2 * INN; hf++) begin
      for (int i = 0; i < 3 + HOLD; i++) begin
        drive(0, 0, 0, 0, i < 3, 0);
        checks++;
        if (w_obs !== exp_vec()) begin
          failures++; $display("FAIL over_seq h%0d c%0d got=%h exp=%h", hf, i, w_obs, exp_vec());
        end
      end
    end
    checks++;
    if (oOVER !== 1'b1 || oINNING !== 4'(INN) || oOUT !== 2'd0 || oBUSY !== 1'b0) begin
      failures++; $display("FAIL over_state got=%h", w_obs);
    end
    for (int i = 0; i < 20; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), 0);
      checks++;
      if (w_obs !== exp_vec()) begin
        failures++; $display("FAIL over_frozen%0d got=%h exp=%h", i, w_obs, exp_vec());
      end
    end
    drive(0, 0, 0, 0, 0, 1);
    checks++;
    if (oINNING !== 4'd1 || oOVER !== 1'b0 || oHALF !== 1'b0) begin
      failures++; $display("FAIL over_reset got=%0d/%b/%b exp=1/0/0", oINNING, oOVER, oHALF);
    end
  endtask

  task automatic test_reset_mid_hold();
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1);
    checks++;
    if (w_obs !== exp_vec() || oBUSY !== 1'b0 || oBALL !== 2'd0) begin
      failures++; $display("FAIL rst_mid_hold got=%h exp=%h", w_obs, exp_vec());
    end
    drive(1, 0, 0, 0, 0, 0);
    checks++;
    if (oBALL !== 2'd1 || w_obs !== exp_vec()) begin
      failures++; $display("FAIL rst_then_ball got=%h exp=%h", w_obs, exp_vec());
    end
  endtask

  task automatic test_random();
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
      checks++;
      if (w_obs !== exp_vec()) begin
        failures++; $display("FAIL random c%0d got=%h exp=%h", i, w_obs, exp_vec());
      end
    end
  endtask

  initial begin
    iRST = 1'b0; iBALL = 1'b0; iSTRIKE = 1'b0; iFOUL = 1'b0; iHIT = 1'b0; iOUT = 1'b0;
    @(negedge iCLK);
    test_reset();
    test_walk();
    test_strikeout();
    test_simultaneous();
    test_side();
    test_game_over();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
